// File: rtl/serial_word_comparator.sv
// Serial MSB-first magnitude comparator: DIGIT_W bits per accepted beat, N_DIGITS beats per word.
// Define SERIAL_WORD_COMPARATOR_SIGNED_EN to compare two's-complement words instead of unsigned.
module serial_word_comparator #(
  parameter int DIGIT_W  = 1,
  parameter int N_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               busy,
  output logic               out_valid,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b
);

  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run_eq;
  logic             r_run_gt;
  logic             r_out_valid;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;

  logic               w_first;
  logic               w_last;
  logic               w_eq;
  logic               w_gt;
  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic               w_eq_n;
  logic               w_gt_n;
  logic               w_lt_n;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LAST_CNT);

  // A word starts fresh on digit 0 regardless of what the running state holds.
  assign w_eq = w_first ? 1'b1 : r_run_eq;
  assign w_gt = w_first ? 1'b0 : r_run_gt;

`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
  // Offset-binary mapping: flipping the sign bit of the leading digit makes
  // an unsigned compare order two's-complement words correctly.
  logic [DIGIT_W-1:0] w_flip;
  always_comb begin
    w_flip = '0;
    w_flip[DIGIT_W-1] = w_first;
  end
  assign w_a_dig = a ^ w_flip;
  assign w_b_dig = b ^ w_flip;
`else
  assign w_a_dig = a;
  assign w_b_dig = b;
`endif

  assign w_eq_n = w_eq & (w_a_dig == w_b_dig);
  assign w_gt_n = w_gt | (w_eq & (w_a_dig > w_b_dig));
  assign w_lt_n = ~w_eq_n & ~w_gt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_run_eq    <= 1'b1;
      r_run_gt    <= 1'b0;
      r_out_valid <= 1'b0;
      r_lt        <= 1'b0;
      r_eq        <= 1'b1;
      r_gt        <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (clear) begin
        r_cnt    <= '0;
        r_run_eq <= 1'b1;
        r_run_gt <= 1'b0;
      end else if (in_valid) begin
        if (w_last) begin
          r_cnt       <= '0;
          r_run_eq    <= 1'b1;
          r_run_gt    <= 1'b0;
          r_out_valid <= 1'b1;
          r_lt        <= w_lt_n;
          r_eq        <= w_eq_n;
          r_gt        <= w_gt_n;
        end else begin
          r_cnt    <= r_cnt + CNT_W'(1);
          r_run_eq <= w_eq_n;
          r_run_gt <= w_gt_n;
        end
      end
    end
  end

  assign busy        = (r_cnt != '0);
  assign out_valid   = r_out_valid;
  assign a_less_b    = r_lt;
  assign a_eq_b      = r_eq;
  assign a_greater_b = r_gt;

endmodule
